fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register. It sits directly upstream of the decode/control stage.
- Owns the PC and drives the instruction-memory address.
- Registers the fetched instruction and its PC+4 into decode, together with the per-instruction kill flag.
- Reacts to decode's taken-branch redirect, load-stall and kill requests, and to a halt request on TRAP.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_stage_if_id_reg.sv | 29 ++
 rtl/fetch_stage.sv | 66 ++++++
 tb/tb_fetch_stage.sv | 126 ++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: encodings and fetch state shared by the fetch and decode/control stages
package fetch_pkg;
    localparam logic [31:0] NOP = 32'h0000_0015;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQZ = 6'h04;
    localparam logic [5:0] OP_BNEZ = 6'h05;
    localparam logic [5:0] OP_TRAP = 6'h11;
    localparam logic [5:0] OP_LB   = 6'h20;
    localparam logic [5:0] OP_LH   = 6'h21;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_LBU  = 6'h24;
    localparam logic [5:0] OP_LHU  = 6'h25;
    typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_t;
endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with bubble insertion
module if_id_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bubble,
    input  logic [0:31] instr_d,
    input  logic [31:0] pc4_d,
    input  logic        kill_d,
    output logic [0:31] instr,
    output logic [31:0] pc_plus_four,
    output logic        should_be_killed
);
    always_ff @(posedge clk) begin
        if (reset) begin
            instr            <= NOP_INSTR;
            pc_plus_four     <= RESET_PC + 32'd4;
            should_be_killed <= 1'b1;
        end else begin
            instr            <= bubble ? NOP_INSTR : instr_d;
            pc_plus_four     <= pc4_d;
            should_be_killed <= bubble | kill_d;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, next-PC selection and BOOT/RUN/HALT control feeding IF/ID
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [0:31] imem_data,
    input  logic        imem_ready,
    input  logic        branch,
    input  logic [31:0] new_pc,
    input  logic        stall,
    input  logic        kill_next,
    input  logic        halt,
    output logic [0:31] instr,
    output logic [31:0] pc_plus_four,
    output logic        should_be_killed,
    output logic        halted,
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count
);
    fetch_state_t state, state_next;
    logic [31:0] pc, pc_next, pc4;
    logic run, bubble, killed;
    always_ff @(posedge clk) begin
        if (reset) state <= BOOT;
        else state <= state_next;
    end
    always_comb begin
        state_next = state == BOOT ? RUN : (state == RUN && halt) ? HALT : state;
    end
    always_comb begin
        pc4     = pc + 32'd4;
        run     = state == RUN;
        bubble  = !run || !imem_ready;
        killed  = bubble || kill_next;
        halted  = state == HALT;
        pc_next = !run ? pc : branch ? new_pc : (stall || !imem_ready) ? pc : pc4;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= RESET_PC;
            fetch_count  <= '0;
            bubble_count <= '0;
        end else begin
            pc           <= pc_next;
            fetch_count  <= fetch_count + {31'b0, !killed};
            bubble_count <= bubble_count + {31'b0, killed};
        end
    end
    assign imem_addr = pc;
    if_id_reg #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) u_if_id (
        .clk              (clk),
        .reset            (reset),
        .bubble           (bubble),
        .instr_d          (imem_data),
        .pc4_d            (pc4),
        .kill_d           (kill_next),
        .instr            (instr),
        .pc_plus_four     (pc_plus_four),
        .should_be_killed (should_be_killed)
    );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios for fetch_stage with hand-computed expectations
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset, imem_ready, branch, stall, kill_next, halt;
    logic [31:0] imem_addr, new_pc, pc_plus_four, fetch_count, bubble_count;
    logic [0:31] imem_data, instr;
    logic        should_be_killed, halted;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    assign imem_data = imem_addr | 32'h1000_0000;
    fetch_stage dut (
        .clk              (clk),
        .reset            (reset),
        .imem_addr        (imem_addr),
        .imem_data        (imem_data),
        .imem_ready       (imem_ready),
        .branch           (branch),
        .new_pc           (new_pc),
        .stall            (stall),
        .kill_next        (kill_next),
        .halt             (halt),
        .instr            (instr),
        .pc_plus_four     (pc_plus_four),
        .should_be_killed (should_be_killed),
        .halted           (halted),
        .fetch_count      (fetch_count),
        .bubble_count     (bubble_count)
    );
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset;
        reset = 1; imem_ready = 1; branch = 0; stall = 0; kill_next = 0; halt = 0; new_pc = 0;
        tick(); tick();
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected %h", imem_addr, 32'h0); end
        checks++; if (instr !== 32'h15) begin errors++; $display("FAIL reset_instr: got %h expected %h", instr, 32'h15); end
        checks++; if (pc_plus_four !== 32'h4) begin errors++; $display("FAIL reset_pc4: got %h expected %h", pc_plus_four, 32'h4); end
        checks++; if (should_be_killed !== 1'b1) begin errors++; $display("FAIL reset_kill: got %b expected 1", should_be_killed); end
        checks++; if ({halted, fetch_count, bubble_count} !== 65'h0) begin errors++; $display("FAIL reset_status: got %b %h %h expected 0 0 0", halted, fetch_count, bubble_count); end
    endtask
    task automatic test_sequential;
        reset = 0;
        tick();
        checks++; if ({should_be_killed, instr} !== {1'b1, 32'h15}) begin errors++; $display("FAIL boot_bubble: got %b %h expected 1 00000015", should_be_killed, instr); end
        checks++; if ({imem_addr, bubble_count} !== {32'h0, 32'd1}) begin errors++; $display("FAIL boot_hold: got %h %0d expected 0 1", imem_addr, bubble_count); end
        tick();
        checks++; if ({instr, pc_plus_four, imem_addr, should_be_killed} !== {32'h1000_0000, 32'h4, 32'h4, 1'b0}) begin errors++; $display("FAIL seq0: got %h %h %h %b expected 10000000 4 4 0", instr, pc_plus_four, imem_addr, should_be_killed); end
        tick();
        checks++; if ({instr, pc_plus_four, imem_addr, fetch_count} !== {32'h1000_0004, 32'h8, 32'h8, 32'd2}) begin errors++; $display("FAIL seq1: got %h %h %h %0d expected 10000004 8 8 2", instr, pc_plus_four, imem_addr, fetch_count); end
    endtask
    task automatic test_load_stall;
        stall = 1; kill_next = 1;
        tick();
        checks++; if ({instr, should_be_killed, imem_addr, bubble_count} !== {32'h1000_0008, 1'b1, 32'h8, 32'd2}) begin errors++; $display("FAIL stall_killed: got %h %b %h %0d expected 10000008 1 8 2", instr, should_be_killed, imem_addr, bubble_count); end
        stall = 0; kill_next = 0;
        tick();
        checks++; if ({instr, should_be_killed, pc_plus_four, imem_addr, fetch_count} !== {32'h1000_0008, 1'b0, 32'hC, 32'hC, 32'd3}) begin errors++; $display("FAIL stall_refetch: got %h %b %h %h %0d expected 10000008 0 c c 3", instr, should_be_killed, pc_plus_four, imem_addr, fetch_count); end
        tick();
        checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL stall_resume: got %h expected 10", imem_addr); end
    endtask
    task automatic test_branch;
        branch = 1; new_pc = 32'h100; kill_next = 1;
        tick();
        checks++; if ({imem_addr, instr, should_be_killed} !== {32'h100, 32'h1000_0010, 1'b1}) begin errors++; $display("FAIL branch_squash: got %h %h %b expected 100 10000010 1", imem_addr, instr, should_be_killed); end
        branch = 0; kill_next = 0;
        tick();
        checks++; if ({instr, pc_plus_four, should_be_killed, imem_addr} !== {32'h1000_0100, 32'h104, 1'b0, 32'h104}) begin errors++; $display("FAIL branch_target: got %h %h %b %h expected 10000100 104 0 104", instr, pc_plus_four, should_be_killed, imem_addr); end
    endtask
    task automatic test_not_ready;
        imem_ready = 0;
        tick();
        checks++; if ({instr, should_be_killed, pc_plus_four, imem_addr} !== {32'h15, 1'b1, 32'h108, 32'h104}) begin errors++; $display("FAIL nr_first: got %h %b %h %h expected 15 1 108 104", instr, should_be_killed, pc_plus_four, imem_addr); end
        branch = 1; new_pc = 32'h40;
        tick();
        checks++; if ({instr, should_be_killed, imem_addr} !== {32'h15, 1'b1, 32'h40}) begin errors++; $display("FAIL nr_redirect: got %h %b %h expected 15 1 40", instr, should_be_killed, imem_addr); end
        branch = 0;
        tick();
        checks++; if ({instr, pc_plus_four, imem_addr, bubble_count} !== {32'h15, 32'h44, 32'h40, 32'd6}) begin errors++; $display("FAIL nr_third: got %h %h %h %0d expected 15 44 40 6", instr, pc_plus_four, imem_addr, bubble_count); end
        imem_ready = 1;
        tick();
        checks++; if ({instr, pc_plus_four, should_be_killed, imem_addr, fetch_count} !== {32'h1000_0040, 32'h44, 1'b0, 32'h44, 32'd6}) begin errors++; $display("FAIL nr_resume: got %h %h %b %h %0d expected 10000040 44 0 44 6", instr, pc_plus_four, should_be_killed, imem_addr, fetch_count); end
    endtask
    task automatic test_halt;
        branch = 1; new_pc = 32'h20; kill_next = 1;
        tick();
        branch = 0; kill_next = 0; halt = 1;
        tick();
        checks++; if ({halted, imem_addr, instr, fetch_count, bubble_count} !== {1'b1, 32'h24, 32'h1000_0020, 32'd7, 32'd7}) begin errors++; $display("FAIL halt_enter: got %b %h %h %0d %0d expected 1 24 10000020 7 7", halted, imem_addr, instr, fetch_count, bubble_count); end
        branch = 1; new_pc = 32'h300; stall = 1;
        for (int i = 0; i < 5; i++) tick();
        checks++; if ({halted, imem_addr, instr, should_be_killed} !== {1'b1, 32'h24, 32'h15, 1'b1}) begin errors++; $display("FAIL halt_frozen: got %b %h %h %b expected 1 24 15 1", halted, imem_addr, instr, should_be_killed); end
        checks++; if ({fetch_count, bubble_count} !== {32'd7, 32'd12}) begin errors++; $display("FAIL halt_counts: got %0d %0d expected 7 12", fetch_count, bubble_count); end
    endtask
    task automatic test_reset_from_halt;
        reset = 1; branch = 0; stall = 0; halt = 0;
        tick();
        checks++; if ({halted, imem_addr, fetch_count, bubble_count} !== {1'b0, 32'h0, 32'h0, 32'h0}) begin errors++; $display("FAIL rst_halt: got %b %h %0d %0d expected 0 0 0 0", halted, imem_addr, fetch_count, bubble_count); end
        reset = 0;
        tick();
        checks++; if ({should_be_killed, instr, imem_addr, bubble_count} !== {1'b1, 32'h15, 32'h0, 32'd1}) begin errors++; $display("FAIL rst_boot: got %b %h %h %0d expected 1 15 0 1", should_be_killed, instr, imem_addr, bubble_count); end
        tick();
        checks++; if ({instr, imem_addr} !== {32'h1000_0000, 32'h4}) begin errors++; $display("FAIL rst_run: got %h %h expected 10000000 4", instr, imem_addr); end
    endtask
    task automatic test_wrap;
        branch = 1; new_pc = 32'hFFFF_FFFC; kill_next = 1;
        tick();
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_target: got %h expected fffffffc", imem_addr); end
        branch = 0; kill_next = 0;
        tick();
        checks++; if ({imem_addr, pc_plus_four, instr, should_be_killed} !== {32'h0, 32'h0, 32'hFFFF_FFFC, 1'b0}) begin errors++; $display("FAIL wrap: got %h %h %h %b expected 0 0 fffffffc 0", imem_addr, pc_plus_four, instr, should_be_killed); end
    endtask
    initial begin
        test_reset();
        test_sequential();
        test_load_stall();
        test_branch();
        test_not_ready();
        test_halt();
        test_reset_from_halt();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
